// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the control pipeline: opcode classes, write sources,
// FSM state encodings and the decoded-instruction record.
package ctrl_pipe_pkg;

  localparam logic [2:0] kLSH = 3'd0;
  localparam logic [2:0] kRSH = 3'd1;
  localparam logic [2:0] kORR = 3'd2;
  localparam logic [2:0] kXOR = 3'd3;
  localparam logic [2:0] kRXR = 3'd4;
  localparam logic [2:0] kADD = 3'd5;
  localparam logic [2:0] kSUB = 3'd6;

  localparam logic [3:0] kACC_REG = 4'd8;
  localparam logic [8:0] kHALT    = 9'h1FF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } ctrl_state_t;

  typedef enum logic [3:0] {
    OP_LSL,
    OP_LSR,
    OP_XOR,
    OP_RXR,
    OP_ORR,
    OP_ADDSUB,
    OP_MOV,
    OP_JMP,
    OP_SPC,
    OP_LUT,
    OP_HALT,
    OP_ILLEGAL
  } op_t;

  typedef enum logic [2:0] {
    WS_ALU     = 3'd0,
    WS_DMEM    = 3'd1,
    WS_LUT_LSW = 3'd2,
    WS_LUT_MSW = 3'd3,
    WS_IMM     = 3'd4
  } wsrc_t;

  // Native-width decode record; the top zero-extends fields to the port widths.
  typedef struct packed {
    logic       reg_wr;
    logic       mem_wr;
    logic       jeq;
    logic       jne;
    logic       offset_en;
    logic       illegal;
    logic [1:0] pcsel;
    wsrc_t      wsrc;
    logic [2:0] alu_op;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rw;
    logic [4:0] imm;
  } ctrl_dec_t;

  function automatic logic [3:0] reg3(input logic [2:0] f);
    return {1'b0, f};
  endfunction

endpackage

// File: rtl/ctrl_pipe_decode.sv
// Combinational decoder for the 9-bit ISA: instruction word -> decoded control record.
// The opcode window is the top nine bits of the instruction; lower bits are ignored.
module ctrl_decode
  import ctrl_pipe_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic [IW-1:0] instr,
  output ctrl_dec_t     dec,
  output logic          halt
);

  logic [8:0] i;
  op_t        op;

  assign i    = instr[IW-1 -: 9];
  assign halt = (op == OP_HALT);

  // All-ones is checked before the opcode table so it wins over mov.
  always_comb begin
    op = OP_ILLEGAL;
    if (i == kHALT) begin
      op = OP_HALT;
    end else begin
      casez (i[8:5])
        4'b000?: op = OP_LSL;
        4'b001?: op = OP_LSR;
        4'b0110: op = OP_XOR;
        4'b0111: op = OP_RXR;
        4'b1101: op = OP_ORR;
        4'b1110: op = OP_ADDSUB;
        4'b1111: op = OP_MOV;
        4'b1000: op = OP_JMP;
        4'b1001: op = OP_SPC;
        4'b1010: op = OP_LUT;
        default: op = OP_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    dec = '0;
    case (op)
      OP_LSL, OP_LSR: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = (op == OP_LSL) ? kLSH : kRSH;
        dec.rw     = reg3(i[5:3]);
        dec.ra     = kACC_REG;
        dec.rb     = reg3(i[2:0]);
      end
      OP_XOR: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = kXOR;
        dec.rw     = reg3(i[4:2]);
        dec.ra     = reg3(i[4:2]);
        dec.rb     = kACC_REG;
      end
      OP_RXR: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = kRXR;
        dec.rw     = reg3(i[4:2]);
        dec.ra     = reg3(i[4:2]);
      end
      OP_ORR: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = kORR;
        dec.rw     = reg3(i[4:2]);
        dec.ra     = reg3(i[4:2]);
        dec.rb     = reg3({1'b1, i[1:0]});
      end
      OP_ADDSUB: begin
        dec.reg_wr = 1'b1;
        dec.alu_op = i[1] ? kSUB : kADD;
        dec.rw     = reg3(i[4:2]);
        dec.ra     = reg3(i[4:2]);
        dec.rb     = kACC_REG;
      end
      OP_MOV: begin
        dec.reg_wr = 1'b1;
        dec.wsrc   = WS_IMM;
        dec.rw     = kACC_REG;
        dec.imm    = i[4:0];
      end
      OP_JMP: begin
        dec.pcsel = i[3:2];
        dec.jne   = i[4];
        dec.jeq   = ~i[4];
      end
      OP_SPC: begin
        dec.pcsel     = i[4:3];
        dec.offset_en = i[2];
      end
      OP_LUT: begin
        dec.reg_wr = 1'b1;
        dec.rw     = kACC_REG;
        if (i[1]) begin
          dec.wsrc = WS_LUT_MSW;
          dec.rb   = reg3(i[4:2]);
        end else begin
          dec.wsrc = WS_LUT_LSW;
          dec.ra   = reg3(i[4:2]);
        end
      end
      OP_HALT: dec = '0;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control unit between instruction ROM and datapath: decode pipeline register,
// IDLE/RUN/DONE program FSM with Start/Ack handshake, and a saturating retire counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int IW      = 9,
  parameter int RA_W    = 4,
  parameter int PCSEL_W = 2,
  parameter int IMM_W   = 8,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [IW-1:0]      Instruction,
  input  logic               Stall,
  input  logic               BranchTaken,
  output logic               FetchEn,
  output logic               RegWrEn,
  output logic               MemWrEn,
  output logic               JumpEqual,
  output logic               JumpNotEqual,
  output logic               OffsetEn,
  output logic [PCSEL_W-1:0] PCRegSelect,
  output logic [2:0]         WriteSource,
  output logic [2:0]         ALUOp,
  output logic [RA_W-1:0]    ReadRegAddrA,
  output logic [RA_W-1:0]    ReadRegAddrB,
  output logic [RA_W-1:0]    WriteRegAddr,
  output logic [IMM_W-1:0]   ImmOut,
  output logic               Valid,
  output logic               Illegal,
  output logic               Ack,
  output logic [CNT_W-1:0]   RetireCnt,
  output ctrl_state_t        State
);

  logic [1:0]       state;
  ctrl_dec_t        dec;
  ctrl_dec_t        pipe;
  logic             halt;
  logic             valid;
  logic             ack;
  logic [CNT_W-1:0] cnt;

  ctrl_decode #(.IW(IW)) u_decode (
    .instr (Instruction),
    .dec   (dec),
    .halt  (halt)
  );

  // Handshake: Start is a level sampled in IDLE/DONE and launches a program; Ack rises
  // when HALT retires and holds in DONE until the next Start. Start in RUN is ignored.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      pipe  <= '0;
      valid <= 1'b0;
      ack   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Start) begin
            state <= ST_RUN;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          if (BranchTaken) begin
            pipe  <= '0;
            valid <= 1'b0;
          end else if (Stall) begin
            pipe.illegal <= 1'b0;
          end else if (halt) begin
            pipe  <= '0;
            valid <= 1'b0;
            ack   <= 1'b1;
            state <= ST_DONE;
          end else begin
            pipe  <= dec;
            valid <= 1'b1;
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (Start) begin
            state <= ST_RUN;
            ack   <= 1'b0;
            cnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A live HALT stops the PC in the same cycle it is decoded, unless it is being flushed.
  assign FetchEn = (state == ST_RUN) && !Stall && !(halt && !BranchTaken);

  assign RegWrEn      = pipe.reg_wr;
  assign MemWrEn      = pipe.mem_wr;
  assign JumpEqual    = pipe.jeq;
  assign JumpNotEqual = pipe.jne;
  assign OffsetEn     = pipe.offset_en;
  assign PCRegSelect  = PCSEL_W'(pipe.pcsel);
  assign WriteSource  = pipe.wsrc;
  assign ALUOp        = pipe.alu_op;
  assign ReadRegAddrA = RA_W'(pipe.ra);
  assign ReadRegAddrB = RA_W'(pipe.rb);
  assign WriteRegAddr = RA_W'(pipe.rw);
  assign ImmOut       = IMM_W'(pipe.imm);
  assign Illegal      = pipe.illegal;
  assign Valid        = valid;
  assign Ack          = ack;
  assign RetireCnt    = cnt;
  assign State        = ctrl_state_t'(state);

endmodule
